time_set_ctrl: RTL
==================

# time_set_ctrl

Button-driven controller that sequences user setting of the MM:SS clock. It snapshots the running time, lets the user select and adjust one of four digits, and drives the clock's time-set enable and load values. It holds the enable long enough for the clock's 1 Hz domain to capture the final value, then hands control back so the clock resumes counting.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; documentation only, not used in the arithmetic.
- `BLINK_CYCLES`, 25_000_000, clk cycles per `blink` half-period while editing.
- `COMMIT_CYCLES`, 110_000_000, clk cycles `enable_time_set` is held after confirm. Must exceed one full 1 Hz period of the clock block.
- `TIMEOUT_CYCLES`, 1_000_000_000, inactivity limit in EDIT (used only with `TIME_SET_TIMEOUT_EN`).
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `btn_mode` input 1: enter edit, or confirm. Level, pre-debounced, asynchronous to clk.
- `btn_next` input 1: advance digit selection. Level, pre-debounced.
- `btn_up` input 1: increment selected digit. Level, pre-debounced.
- `btn_down` input 1: decrement selected digit. Level, pre-debounced.
- `current_time_0..3` input 4 each: running clock digits: min tens, min ones, sec tens, sec ones.
- `enable_time_set` output 1: high = clock loads `time_setting_output_*` instead of counting.
- `time_setting_output_0..3` output 4 each: edit registers, same digit order as `current_time_*`.
- `digit_sel` output 2: selected digit index 0..3, for display highlighting.
- `blink` output 1: 1 = show selected digit, 0 = blank it.

## Operation
- Each button passes through a 2-FF synchronizer. A rising-edge detector on the synchronized level yields a 1-cycle event. Only events act; held levels never repeat.
- FSM states:
  - IDLE: `enable_time_set`=0, `blink`=1. A mode event copies `current_time_0..3` into the edit registers, sets `digit_sel`=0, asserts `enable_time_set`, clears the blink and timeout counters, and moves to EDIT. Other events are ignored.
  - EDIT: `enable_time_set`=1.
    - Mode event → COMMIT.
    - Next event → `digit_sel`=(`digit_sel`+1) mod 4.
    - Up/down event → adjust the selected digit with wrap-around.
    - Digit limits: 0 and 2 range 0..5 (5+1→0, 0−1→5); digits 1 and 3 range 0..9 (9+1→0, 0−1→9).
    - Any event restarts the blink phase (`blink`=1) and the timeout counter.
  - COMMIT: `enable_time_set`=1. The edit registers are frozen and all button events are ignored. The state lasts exactly `COMMIT_CYCLES` cycles, then moves to IDLE.
- Priority when several events fall in the same cycle: mode > next > up/down. Only the highest-priority event acts. Up and down together without mode or next cause no change.
- `time_setting_output_*` always reflect the edit registers; they are valid in every state.
- Edit-register values are never outside the digit limits, provided the snapshot inputs are legal.

## Timing
- Reset values:
  - state IDLE, `enable_time_set`=0, `time_setting_output_0..3`=0, `digit_sel`=0, `blink`=1.
  - Synchronizer, edge, blink, commit and timeout registers all 0.
- Button latency: if a button is first sampled high at clk edge N, the resulting action is visible after edge N+2.
- The snapshot is taken on the same edge that enters EDIT; `enable_time_set` rises on that edge.
- In EDIT, `blink` toggles every `BLINK_CYCLES` cycles. Outside EDIT, `blink` is held at 1.
- COMMIT: `enable_time_set` falls on the edge that returns to IDLE, which is `COMMIT_CYCLES` edges after entering COMMIT.
- Reset asserted in any state immediately forces the reset values. Partial edits are discarded and the clock is released.

## Configuration
- `TIME_SET_TIMEOUT_EN` defined: in EDIT, `TIMEOUT_CYCLES` consecutive cycles with no button event force a transition to COMMIT, exactly as a mode event would, so the edited value is applied.
- Not defined: the timeout counter is absent and EDIT persists until a mode event or reset.

## Test plan
- Params BLINK=4, COMMIT=20, TIMEOUT=50.
- Snapshot: current 3,7,5,9; pulse mode → after 2 edges enable=1, outputs 3,7,5,9, `digit_sel`=0, `blink`=1.
- Wrap: in EDIT select digit 0 at value 5, up → 0; select digit 3 at value 0, down → 9; next ×4 returns `digit_sel`=0.
- Priority: mode+up in the same cycle → COMMIT with digits unchanged; up+down together → no change.
- Commit: after mode confirm, enable stays 1 for exactly 20 cycles while up pulses are ignored, then IDLE with enable=0.
- Timeout (macro on): 50 idle cycles in EDIT → COMMIT. With the macro off, 200 idle cycles → still EDIT.
- Reset during EDIT at digits 1,2,3,4 → enable=0, outputs 0, state IDLE on the same edge.

Source files
------------

// File: rtl/time_set_ctrl.sv
// Button-driven MM:SS time-set sequencer: snapshot, per-digit edit, timed commit hold.
// Optional EDIT inactivity timeout is compiled in with `define TIME_SET_TIMEOUT_EN.
module time_set_ctrl #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000,
  parameter int unsigned COMMIT_CYCLES  = 110_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] current_time_0,
  input  logic [3:0] current_time_1,
  input  logic [3:0] current_time_2,
  input  logic [3:0] current_time_3,
  output logic       enable_time_set,
  output logic [3:0] time_setting_output_0,
  output logic [3:0] time_setting_output_1,
  output logic [3:0] time_setting_output_2,
  output logic [3:0] time_setting_output_3,
  output logic [1:0] digit_sel,
  output logic       blink
);

  localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
  localparam int unsigned CW = $clog2(COMMIT_CYCLES + 1);

  // Parameter sanity: the commit hold must outlast one full 1 Hz period.
  if (BLINK_CYCLES == 0) begin : g_bad_blink
    $error("time_set_ctrl: BLINK_CYCLES must be nonzero");
  end
  if (COMMIT_CYCLES <= CLK_HZ) begin : g_bad_commit
    $error("time_set_ctrl: COMMIT_CYCLES must exceed CLK_HZ");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("time_set_ctrl: TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      btn_meta_q, btn_sync_q, btn_prev_q;
  logic [3:0]      btn_evt;
  logic            evt_mode, evt_next, evt_up, evt_down, any_evt;
  logic [3:0][3:0] dig_q, dig_d;
  logic [1:0]      sel_q, sel_d;
  logic            blink_q, blink_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [CW-1:0]   commit_cnt_q, commit_cnt_d;
  logic            tmo_expired;

  function automatic logic [3:0] step_digit(input logic [3:0] v,
                                            input logic [3:0] lim,
                                            input logic       up);
    logic [3:0] r;
    if (up) r = (v >= lim) ? 4'd0 : v + 4'd1;
    else    r = (v == 4'd0 || v > lim) ? lim : v - 4'd1;
    return r;
  endfunction

  always_comb begin
    btn_evt  = btn_sync_q & ~btn_prev_q;
    evt_mode = btn_evt[0];
    evt_next = btn_evt[1];
    evt_up   = btn_evt[2];
    evt_down = btn_evt[3];
    any_evt  = |btn_evt;
  end

`ifdef TIME_SET_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counter runs only while EDIT is quiet; entry and every event restart it.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_EDIT && !any_evt) tmo_cnt_d = tmo_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end

  assign tmo_expired = (state_q == ST_EDIT) && !any_evt &&
                       (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    dig_d        = dig_q;
    sel_d        = sel_q;
    blink_d      = 1'b1;
    blink_cnt_d  = '0;
    commit_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (evt_mode) begin
          dig_d[0] = current_time_0;
          dig_d[1] = current_time_1;
          dig_d[2] = current_time_2;
          dig_d[3] = current_time_3;
          sel_d    = 2'd0;
          state_d  = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (!any_evt) begin
          if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_d = ~blink_q;
          end else begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
        if (evt_mode) begin
          state_d = ST_COMMIT;
        end else if (evt_next) begin
          sel_d = sel_q + 2'd1;
        end else if (evt_up ^ evt_down) begin
          // Even indices are tens digits (0..5), odd are ones digits (0..9).
          dig_d[sel_q] = step_digit(dig_q[sel_q], sel_q[0] ? 4'd9 : 4'd5, evt_up);
        end else if (tmo_expired) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (commit_cnt_q == CW'(COMMIT_CYCLES - 1)) state_d = ST_IDLE;
        else commit_cnt_d = commit_cnt_q + CW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q   <= '0;
      btn_sync_q   <= '0;
      btn_prev_q   <= '0;
      state_q      <= ST_IDLE;
      dig_q        <= '0;
      sel_q        <= '0;
      blink_q      <= 1'b1;
      blink_cnt_q  <= '0;
      commit_cnt_q <= '0;
    end else begin
      btn_meta_q   <= {btn_down, btn_up, btn_next, btn_mode};
      btn_sync_q   <= btn_meta_q;
      btn_prev_q   <= btn_sync_q;
      state_q      <= state_d;
      dig_q        <= dig_d;
      sel_q        <= sel_d;
      blink_q      <= blink_d;
      blink_cnt_q  <= blink_cnt_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign enable_time_set       = (state_q != ST_IDLE);
  assign time_setting_output_0 = dig_q[0];
  assign time_setting_output_1 = dig_q[1];
  assign time_setting_output_2 = dig_q[2];
  assign time_setting_output_3 = dig_q[3];
  assign digit_sel             = sel_q;
  assign blink                 = blink_q;

endmodule
